speicher_steuerung: RTL and testbench

- Memory controller between the processor's load/store/fetch path and the single-port synchronous RAM (write-or-read per clock, registered read data, no reset).
- Accepts one CPU request at a time over a request/done handshake and sequences the RAM's one-cycle read latency.
- Decodes address bit 31 as memory-mapped I/O: a 32-bit output register (Ausgabe) for the program's counter/LED output.

---
 rtl/speicher_steuerung.sv | 181 ++++++++++++++++++
 tb/tb_speicher_steuerung.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/speicher_steuerung.sv
// -----------------------------------------------------------------------------
// speicher_steuerung
//
// Memory controller between the CPU load/store/fetch path and a single-port
// synchronous RAM. The RAM does one write or one read per clock, returns read
// data registered one cycle later and has no reset.
//
// Only one CPU request is in flight at a time. The CPU raises Anfrage and
// keeps it high until it sees the one-cycle Fertig pulse. The top CPU address
// bit (bit 31 at the default width) selects memory-mapped I/O instead of RAM.
// The only I/O device is the 32-bit output register Ausgabe, which the program
// uses to drive its counter/LED output.
//
// Request timing, counting the accepting cycle as cycle 0:
//   RAM read  : LEERLAUF -> ZUGRIFF -> ANTWORT -> FERTIG  (Fertig in cycle 3)
//   RAM write : LEERLAUF -> ZUGRIFF -> FERTIG             (Fertig in cycle 2)
//   I/O       : LEERLAUF -> FERTIG                        (Fertig in cycle 1)
//
// Ports
//   Clock           in   system clock; all state changes on the rising edge
//   Reset           in   synchronous, active-high reset
//   Anfrage         in   CPU request valid, held until Fertig
//   Schreiben       in   1 = store, 0 = load; sampled with Anfrage
//   CpuAdresse      in   CPU word address; top bit selects I/O
//   CpuDatenRein    in   store data
//   CpuDatenRaus    out  load result, valid while Fertig = 1
//   Fertig          out  one-cycle done pulse
//   RamSchreibenAn  out  RAM write enable
//   RamAdresse      out  RAM word address
//   RamDatenRein    out  RAM write data
//   RamDatenRaus    in   RAM registered read data
//   Ausgabe         out  I/O output register
//   AusgabeGueltig  out  one-cycle pulse after each I/O write
// -----------------------------------------------------------------------------
module speicher_steuerung #(
  parameter int WORDSIZE     = 32,
  parameter int WORDS        = 256,
  parameter int ADRESSBREITE = 32
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Anfrage,
  input  logic                     Schreiben,
  input  logic [ADRESSBREITE-1:0]  CpuAdresse,
  input  logic [WORDSIZE-1:0]      CpuDatenRein,
  output logic [WORDSIZE-1:0]      CpuDatenRaus,
  output logic                     Fertig,
  output logic                     RamSchreibenAn,
  output logic [$clog2(WORDS)-1:0] RamAdresse,
  output logic [WORDSIZE-1:0]      RamDatenRein,
  input  logic [WORDSIZE-1:0]      RamDatenRaus,
  output logic [WORDSIZE-1:0]      Ausgabe,
  output logic                     AusgabeGueltig
);

  localparam int RAMBREITE = $clog2(WORDS);
  // The I/O select is the most significant CPU address bit.
  localparam int IO_BIT    = ADRESSBREITE - 1;

  typedef enum logic [1:0] {
    LEERLAUF = 2'd0,
    ZUGRIFF  = 2'd1,
    ANTWORT  = 2'd2,
    FERTIG   = 2'd3
  } zustand_t;

  zustand_t                  zustand;
  zustand_t                  naechster;

  logic [ADRESSBREITE-1:0]   adresse_reg;
  logic [WORDSIZE-1:0]       daten_reg;
  logic                      schreiben_reg;

  logic                      annahme;
  logic                      io_anfrage;
  logic                      io_reg;

  // A request is taken only in LEERLAUF; Anfrage seen in FERTIG is ignored.
  assign annahme    = (zustand == LEERLAUF) && Anfrage;
  assign io_anfrage = CpuAdresse[IO_BIT];
  assign io_reg     = adresse_reg[IO_BIT];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand <= LEERLAUF;
    end else begin
      zustand <= naechster;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    naechster = zustand;
    case (zustand)
      LEERLAUF: begin
        if (Anfrage) begin
          // I/O completes in a single cycle, both for reads and writes.
          naechster = io_anfrage ? FERTIG : ZUGRIFF;
        end
      end
      ZUGRIFF: begin
        // A write is committed at this edge; a read still needs the
        // RAM's registered output cycle.
        naechster = schreiben_reg ? FERTIG : ANTWORT;
      end
      ANTWORT: begin
        naechster = FERTIG;
      end
      FERTIG: begin
        naechster = LEERLAUF;
      end
      default: begin
        naechster = LEERLAUF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    Fertig         = 1'b0;
    AusgabeGueltig = 1'b0;
    RamSchreibenAn = 1'b0;
    case (zustand)
      ZUGRIFF: begin
        // Reset gates the enable so a write in flight is dropped at once.
        RamSchreibenAn = schreiben_reg && !Reset;
      end
      FERTIG: begin
        Fertig         = 1'b1;
        AusgabeGueltig = io_reg && schreiben_reg;
      end
      default: begin
        Fertig         = 1'b0;
      end
    endcase
  end

  // The RAM side simply mirrors the latched request in every state; only
  // the write enable is state dependent. Upper address bits below the I/O
  // bit are dropped, so RAM addresses alias modulo WORDS.
  assign RamAdresse   = adresse_reg[RAMBREITE-1:0];
  assign RamDatenRein = daten_reg;

  // ---------------------------------------------------------------------------
  // Request latch, load result and I/O output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      adresse_reg   <= '0;
      daten_reg     <= '0;
      schreiben_reg <= 1'b0;
      CpuDatenRaus  <= '0;
      Ausgabe       <= '0;
    end else begin
      if (annahme) begin
        adresse_reg   <= CpuAdresse;
        daten_reg     <= CpuDatenRein;
        schreiben_reg <= Schreiben;
        if (io_anfrage) begin
          if (Schreiben) begin
            Ausgabe      <= CpuDatenRein;
          end else begin
            CpuDatenRaus <= Ausgabe;
          end
        end
      end
      // RAM read data is valid during ANTWORT and is captured for FERTIG.
      if (zustand == ANTWORT) begin
        CpuDatenRaus <= RamDatenRaus;
      end
    end
  end

endmodule

// File: tb/tb_speicher_steuerung.sv
module tb_speicher_steuerung;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Anfrage;
  logic        Schreiben;
  logic [31:0] CpuAdresse;
  logic [31:0] CpuDatenRein;
  logic [31:0] CpuDatenRaus;
  logic        Fertig;
  logic        RamSchreibenAn;
  logic [7:0]  RamAdresse;
  logic [31:0] RamDatenRein;
  logic [31:0] RamDatenRaus = '0;
  logic [31:0] Ausgabe;
  logic        AusgabeGueltig;

  int checks   = 0;
  int failures = 0;

  speicher_steuerung #(
    .WORDSIZE    (32),
    .WORDS       (256),
    .ADRESSBREITE(32)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Anfrage       (Anfrage),
    .Schreiben     (Schreiben),
    .CpuAdresse    (CpuAdresse),
    .CpuDatenRein  (CpuDatenRein),
    .CpuDatenRaus  (CpuDatenRaus),
    .Fertig        (Fertig),
    .RamSchreibenAn(RamSchreibenAn),
    .RamAdresse    (RamAdresse),
    .RamDatenRein  (RamDatenRein),
    .RamDatenRaus  (RamDatenRaus),
    .Ausgabe       (Ausgabe),
    .AusgabeGueltig(AusgabeGueltig)
  );

  always #5 Clock = ~Clock;

  // Single-port synchronous RAM: one write or read per clock, registered
  // read data, no reset.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge Clock) begin
    if (RamSchreibenAn) mem[RamAdresse] <= RamDatenRein;
    RamDatenRaus <= mem[RamAdresse];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Presents one request, holds Anfrage until Fertig, then drops it.
  // lat counts cycles from the accepting cycle (0) to the Fertig cycle.
  task automatic run_req(input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                         output int lat, output int nwr, output logic [7:0] wadr,
                         output logic [31:0] wdat, output int ngue,
                         output logic [31:0] raus, output logic [31:0] ausg);
    @(posedge Clock); #1;
    Anfrage = 1'b1; Schreiben = wr; CpuAdresse = adr; CpuDatenRein = dat;
    lat = -1; nwr = 0; ngue = 0; wadr = '0; wdat = '0; raus = '0; ausg = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (RamSchreibenAn) begin nwr++; wadr = RamAdresse; wdat = RamDatenRein; end
      if (AusgabeGueltig) ngue++;
      if (Fertig) begin
        lat = c; raus = CpuDatenRaus; ausg = Ausgabe;
        break;
      end
      @(posedge Clock); #1;
    end
    @(posedge Clock); #1;
    Anfrage = 1'b0;
    @(negedge Clock);
    check("fertig_single_pulse", {31'b0, Fertig}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] dat;
    int          lat;
    int          nwr;
    logic [7:0]  wadr;
    int          ngue;
    logic [31:0] raus;
    logic [31:0] ausg;
  } vec_t;

  vec_t vecs [11];

  int          lat, nwr, ngue, nbad_f, nbad_w, pulses;
  logic [7:0]  wadr;
  logic [31:0] wdat, raus, ausg;

  initial begin
    // wr adr dat | lat nwr wadr ngue raus ausg
    vecs[0]  = '{1'b1, 32'h0000_0003, 32'h3333_3333, 2, 1, 8'h03, 0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 2, 1, 8'h05, 0, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0005, 32'h0,         3, 0, 8'h00, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'h0000_0007, 1, 0, 8'h00, 1, 32'hDEAD_BEEF, 32'h7};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0,         1, 0, 8'h00, 0, 32'h7,         32'h7};
    vecs[5]  = '{1'b1, 32'h0000_0105, 32'h0000_0011, 2, 1, 8'h05, 0, 32'h7,         32'h7};
    vecs[6]  = '{1'b0, 32'h0000_0005, 32'h0,         3, 0, 8'h00, 0, 32'h11,        32'h7};
    vecs[7]  = '{1'b0, 32'h7FFF_FF05, 32'h0,         3, 0, 8'h00, 0, 32'h11,        32'h7};
    vecs[8]  = '{1'b1, 32'h0000_00FF, 32'hA5A5_A5A5, 2, 1, 8'hFF, 0, 32'h11,        32'h7};
    vecs[9]  = '{1'b0, 32'h0000_00FF, 32'h0,         3, 0, 8'h00, 0, 32'hA5A5_A5A5, 32'h7};
    vecs[10] = '{1'b0, 32'h0000_0003, 32'h0,         3, 0, 8'h00, 0, 32'h3333_3333, 32'h7};

    Reset = 1'b1; Anfrage = 1'b0; Schreiben = 1'b0; CpuAdresse = '0; CpuDatenRein = '0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;

    // Idle after reset: nothing may happen.
    nbad_f = 0; nbad_w = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (Fertig !== 1'b0) nbad_f++;
      if (RamSchreibenAn !== 1'b0) nbad_w++;
    end
    check("idle_fertig_cycles", nbad_f, 0);
    check("idle_ramwrite_cycles", nbad_w, 0);
    check("reset_ausgabe", Ausgabe, 32'h0);
    check("reset_cpudatenraus", CpuDatenRaus, 32'h0);
    check("reset_ausgabegueltig", {31'b0, AusgabeGueltig}, 32'h0);

    // Table of single requests.
    for (int i = 0; i < 11; i++) begin
      run_req(vecs[i].wr, vecs[i].adr, vecs[i].dat, lat, nwr, wadr, wdat, ngue, raus, ausg);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_ram_writes", i), nwr, vecs[i].nwr);
      check($sformatf("v%0d_gueltig_pulses", i), ngue, vecs[i].ngue);
      check($sformatf("v%0d_cpudatenraus", i), raus, vecs[i].raus);
      check($sformatf("v%0d_ausgabe", i), ausg, vecs[i].ausg);
      if (vecs[i].nwr > 0) begin
        check($sformatf("v%0d_ram_adresse", i), {24'b0, wadr}, {24'b0, vecs[i].wadr});
        check($sformatf("v%0d_ram_daten", i), wdat, vecs[i].dat);
      end
    end

    // Reset during the ZUGRIFF cycle of a store to address 3.
    @(posedge Clock); #1;
    Anfrage = 1'b1; Schreiben = 1'b1; CpuAdresse = 32'h3; CpuDatenRein = 32'h0000_0BAD;
    @(posedge Clock); #1;          // accepted, now in ZUGRIFF
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_write_enable", {31'b0, RamSchreibenAn}, 32'h0);
    @(posedge Clock); #1;
    Reset = 1'b0; Anfrage = 1'b0;
    nbad_f = 0; nbad_w = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      if (Fertig !== 1'b0) nbad_f++;
      if (RamSchreibenAn !== 1'b0) nbad_w++;
    end
    check("abort_no_fertig", nbad_f, 0);
    check("abort_no_ram_write", nbad_w, 0);
    check("abort_ausgabe_cleared", Ausgabe, 32'h0);
    check("abort_cpudatenraus_cleared", CpuDatenRaus, 32'h0);
    run_req(1'b0, 32'h3, 32'h0, lat, nwr, wadr, wdat, ngue, raus, ausg);
    check("abort_load_latency", lat, 3);
    check("abort_load_prior_data", raus, 32'h3333_3333);

    // Eight back-to-back I/O stores with Anfrage held high.
    @(posedge Clock); #1;
    Anfrage = 1'b1; Schreiben = 1'b1; CpuAdresse = 32'h8000_0000; CpuDatenRein = 32'd1;
    pulses = 0;
    for (int c = 0; c < 40 && pulses < 8; c++) begin
      @(negedge Clock);
      if (AusgabeGueltig) begin
        pulses++;
        check($sformatf("burst_pulse%0d_fertig", pulses), {31'b0, Fertig}, 32'h1);
        check($sformatf("burst_pulse%0d_ausgabe", pulses), Ausgabe, pulses);
      end
      @(posedge Clock); #1;
      CpuDatenRein = pulses + 1;
    end
    Anfrage = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      if (AusgabeGueltig) pulses++;
    end
    check("burst_pulse_count", pulses, 8);
    check("burst_final_ausgabe", Ausgabe, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
